// File: rtl/mux4_arb.sv
// rtl/mux4_arb.sv - round-robin arbitrated 4:1 mux with optional hold timeout
//
// Four requesters share one 1-bit 4:1 mux. A two-state FSM (IDLE/GRANT)
// grants one requester at a time. The search for the next owner starts at
// a rotating pointer. After every release the block waits one IDLE cycle
// before it arbitrates again.
//
// Optional feature: define MUX4_ARB_TIMEOUT_EN to compile in an 8-bit hold
// counter. When the owner has held the grant for MAX_HOLD cycles and any
// other requester is waiting, the owner is forced to release.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   req[3:0]   in   request per source (0=a, 1=b, 2=c, 3=d)
//   a,b,c,d    in   data sources of the shared mux
//   gnt[3:0]   out  registered one-hot grant, zero when idle
//   s1, s2     out  registered select, {s1,s2} = index of granted source
//   busy       out  registered, high while in GRANT
//   y          out  combinational mux output, 0 when not busy
module mux4_arb #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       y
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [1:0] r_rr_ptr;
  logic [1:0] w_rr_ptr_nxt;
  // Set for the single IDLE cycle that follows a release; blocks arbitration.
  logic       r_hold_off;
  logic       w_hold_off_nxt;
  logic [1:0] w_pick;
  logic       w_pick_vld;
  logic       w_release;

  // First requester at or after r_rr_ptr, modulo 4. Scanning from the
  // farthest offset down lets the nearest one win.
  always_comb begin
    w_pick     = r_rr_ptr;
    w_pick_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_rr_ptr + 2'(i)]) begin
        w_pick     = r_rr_ptr + 2'(i);
        w_pick_vld = 1'b1;
      end
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_cnt_nxt;
  logic       w_at_limit;
  logic       w_others;

  assign w_at_limit = (r_hold_cnt == 8'(MAX_HOLD - 1));
  assign w_others   = |(req & ~r_gnt);
  assign w_release  = ~|(req & r_gnt) | (w_at_limit & w_others);
`else
  // MAX_HOLD has no effect in this build.
  logic [7:0] w_unused_max_hold;
  assign w_unused_max_hold = 8'(MAX_HOLD);
  assign w_release         = ~|(req & r_gnt);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_sel_nxt      = r_sel;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_off_nxt = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
    w_hold_cnt_nxt = r_hold_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!r_hold_off && w_pick_vld) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'b0001 << w_pick;
          w_sel_nxt   = w_pick;
`ifdef MUX4_ARB_TIMEOUT_EN
          w_hold_cnt_nxt = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt      = 4'b0000;
          w_rr_ptr_nxt   = r_sel + 2'd1;
          w_hold_off_nxt = 1'b1;
        end
`ifdef MUX4_ARB_TIMEOUT_EN
        else if (w_at_limit) begin
          // Nobody else is waiting: restart the hold window.
          w_hold_cnt_nxt = 8'd0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 4'b0000;
      r_sel      <= 2'd0;
      r_rr_ptr   <= 2'd0;
      r_hold_off <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
      r_hold_cnt <= 8'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_off <= w_hold_off_nxt;
`ifdef MUX4_ARB_TIMEOUT_EN
      r_hold_cnt <= w_hold_cnt_nxt;
`endif
    end
  end

  logic w_mux;
  always_comb begin
    case (r_sel)
      2'd0:    w_mux = a;
      2'd1:    w_mux = b;
      2'd2:    w_mux = c;
      default: w_mux = d;
    endcase
  end

  assign gnt  = r_gnt;
  assign s1   = r_sel[1];
  assign s2   = r_sel[0];
  assign busy = (r_state == ST_GRANT);
  assign y    = busy & w_mux;

endmodule

// File: tb/tb_mux4_arb.sv
// tb/tb_mux4_arb.sv - scoreboard bench for mux4_arb against a behavioural model
module tb_mux4_arb;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       a, b, c, d;
  logic [3:0] gnt;
  logic       s1, s2, busy, y;

  always #5 clk = ~clk;

  mux4_arb #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .gnt  (gnt),
    .s1   (s1),
    .s2   (s2),
    .busy (busy),
    .y    (y)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: owner index (-1 when idle), rotation start, last select,
  // hold count and the post-release wait flag.
  int   m_owner = -1;
  int   m_rr    = 0;
  int   m_sel   = 0;
  int   m_cnt   = 0;
  bit   m_wait  = 0;

  logic       cur_rst;
  logic [3:0] cur_req;

  function automatic void model_step();
    bit rel;
    if (!cur_rst) begin
      m_owner = -1; m_rr = 0; m_sel = 0; m_cnt = 0; m_wait = 0;
    end else if (m_owner >= 0) begin
      rel = !cur_req[m_owner];
`ifdef MUX4_ARB_TIMEOUT_EN
      if (m_cnt == MAX_HOLD - 1 && (cur_req & ~(4'b0001 << m_owner)) != 4'b0000) rel = 1;
`endif
      if (rel) begin
        m_rr    = (m_owner + 1) % 4;
        m_owner = -1;
        m_wait  = 1;
      end else begin
        m_cnt = (m_cnt == MAX_HOLD - 1) ? 0 : m_cnt + 1;
      end
    end else if (m_wait) begin
      m_wait = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && cur_req[(m_rr + k) % 4]) begin
          m_owner = (m_rr + k) % 4;
          m_sel   = m_owner;
          m_cnt   = 0;
        end
      end
    end
  endfunction

  // One clock: advance the model over the edge, then drive the inputs for the
  // next edge and queue what the DUT should show until then. In rotate mode
  // the current owner's bit is dropped so each owner holds exactly one cycle.
  task automatic cycle(input logic nrst, input logic [3:0] nreq, input bit rotate);
    logic [3:0] r;
    logic [3:0] src;
    exp_t       e;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    r = nreq;
    if (rotate) r = (m_owner >= 0) ? (4'hF & ~(4'b0001 << m_owner)) : 4'hF;
    rst_n = nrst;
    req   = r;
    {d, c, b, a} = 4'($urandom);
    cur_rst = nrst;
    cur_req = r;
    src    = {d, c, b, a};
    e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    e.y    = e.busy & src[m_sel];
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({gnt, s1, s2, busy, y} === e) n_pass++;
        else $display("FAIL outputs cyc=%0d got gnt=%b s=%b%b busy=%b y=%b want gnt=%b s=%b busy=%b y=%b",
                      cyc, gnt, s1, s2, busy, y, e.gnt, e.sel, e.busy, e.y);
        n_checks++;
        if ($countones(gnt) <= 1 && (!busy || gnt === (4'b0001 << {s1, s2}))) n_pass++;
        else $display("FAIL onehot cyc=%0d got gnt=%b s=%b%b busy=%b want one-hot matching select",
                      cyc, gnt, s1, s2, busy);
      end
    end
  end

  initial begin : stim
    logic [3:0] r;
    rst_n = 1'b0; req = 4'hF; {a, b, c, d} = 4'b0;
    cur_rst = 1'b0; cur_req = 4'hF;

    // Reset held two edges with all requests high, then c alone.
    cycle(1'b0, 4'hF, 0);
    cycle(1'b1, 4'b0100, 0);
    repeat (4) cycle(1'b1, 4'b0100, 0);
    repeat (3) cycle(1'b1, 4'b0000, 0);

    // All requesting, each owner holds one cycle: a, b, c, d, a, ...
    cycle(1'b0, 4'hF, 0);
    repeat (20) cycle(1'b1, 4'hF, 1);

    // b owns while a and d toggle; release b with c quiet -> d next.
    cycle(1'b0, 4'b0000, 0);
    cycle(1'b1, 4'b0010, 0);
    repeat (8) begin
      r = 4'b0010 | (4'($urandom) & 4'b1001);
      cycle(1'b1, r, 0);
    end
    repeat (4) cycle(1'b1, 4'b1001, 0);

    // Reset in the middle of d's grant, then a is favoured.
    cycle(1'b1, 4'b1000, 0);
    repeat (3) cycle(1'b1, 4'b1000, 0);
    cycle(1'b0, 4'hF, 0);
    repeat (4) cycle(1'b1, 4'hF, 0);

    // a held alone, then b raised (timeout path), then a alone for long.
    cycle(1'b0, 4'b0001, 0);
    repeat (12) cycle(1'b1, 4'b0001, 0);
    repeat (12) cycle(1'b1, 4'b0011, 0);
    cycle(1'b1, 4'b0000, 0);
    repeat (3) cycle(1'b1, 4'b0000, 0);
    repeat (20) cycle(1'b1, 4'b0001, 0);

    // Random: slow-changing requests, then high churn, rare resets.
    repeat (3000) begin
      r = cur_req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      cycle(($urandom_range(0, 199) != 0), r, 0);
    end
    repeat (500) begin
      r = 4'($urandom);
      cycle(($urandom_range(0, 99) != 0), r, 0);
    end

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
